// File: rtl/visdrain_if.sv
// ---------------------------------------------------------------------------
// visdrain_if
//   Bundles the parallel-fill side and the serial-drain side of the
//   visibility drain into one interface.
//
//   Handshake rules (both sides):
//     - par_valid_i[k] is a per-lane strobe with no back-pressure. A lane
//       presented while par_ready_o is low, or twice into the same bank, is
//       discarded and raises overflow_o.
//     - On the serial side a word moves on a rising clock edge where
//       seq_valid_o and seq_ready_i are both high. Once seq_valid_o rises,
//       the word and its flags stay unchanged until that transfer.
//
//   Signals
//     par_valid_i  LENGTH        per-lane strobe
//     par_rdata_i  LENGTH*WIDTH  lane k real at [k*WIDTH +: WIDTH]
//     par_idata_i  LENGTH*WIDTH  lane k imag, same packing
//     par_ready_o  1             a fill bank is available
//     seq_valid_o  1             serial word valid
//     seq_ready_i  1             downstream accept
//     seq_first_o  1             first word of a bank
//     seq_last_o   1             last word of a bank
//     seq_index_o  IBITS         source lane of the current word
//     seq_rdata_o  WIDTH         current word real
//     seq_idata_o  WIDTH         current word imag
//     clear_i      1             synchronous clear of overflow_o
//     overflow_o   1             sticky lane-drop flag
// ---------------------------------------------------------------------------
interface visdrain_if #(
    parameter int LENGTH = 5,
    parameter int WIDTH  = 7
);
    localparam int IBITS = $clog2(LENGTH);

    logic [LENGTH-1:0]       par_valid_i;
    logic [LENGTH*WIDTH-1:0] par_rdata_i;
    logic [LENGTH*WIDTH-1:0] par_idata_i;
    logic                    par_ready_o;
    logic                    seq_valid_o;
    logic                    seq_ready_i;
    logic                    seq_first_o;
    logic                    seq_last_o;
    logic [IBITS-1:0]        seq_index_o;
    logic [WIDTH-1:0]        seq_rdata_o;
    logic [WIDTH-1:0]        seq_idata_o;
    logic                    clear_i;
    logic                    overflow_o;

    // The drain block itself.
    modport slave (
        input  par_valid_i, par_rdata_i, par_idata_i, seq_ready_i, clear_i,
        output par_ready_o, seq_valid_o, seq_first_o, seq_last_o,
               seq_index_o, seq_rdata_o, seq_idata_o, overflow_o
    );

    // The surroundings: correlator lanes upstream, word consumer downstream.
    modport master (
        output par_valid_i, par_rdata_i, par_idata_i, seq_ready_i, clear_i,
        input  par_ready_o, seq_valid_o, seq_first_o, seq_last_o,
               seq_index_o, seq_rdata_o, seq_idata_o, overflow_o
    );
endinterface

// File: rtl/visdrain.sv
// ---------------------------------------------------------------------------
// visdrain
//   Collects LENGTH parallel complex correlator lanes into one of two banks
//   (ping-pong) and drains each completed bank as a serial word stream,
//   one lane per word, lane 0 first (REVERSE=0) or lane LENGTH-1 first
//   (REVERSE=1). Data passes bit-exact.
//
//   Ports
//     clock        rising-edge clock
//     reset        asynchronous, active-high
//     bus          visdrain_if.slave (fill side, drain side, overflow)
//     dbg_state_o  read FSM state (0 = IDLE, 1 = EMIT)
// ---------------------------------------------------------------------------
module visdrain #(
    parameter int LENGTH  = 5,
    parameter int WIDTH   = 7,
    parameter int REVERSE = 1
) (
    input  logic       clock,
    input  logic       reset,
    visdrain_if.slave  bus,
    output logic       dbg_state_o
);
    localparam int IBITS = $clog2(LENGTH);
    localparam logic [IBITS-1:0] LAST = IBITS'(LENGTH - 1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Bank storage and pointers
    // ------------------------------------------------------------------
    logic [LENGTH-1:0] r_mask [2];
    logic [WIDTH-1:0]  r_re   [2][LENGTH];
    logic [WIDTH-1:0]  r_im   [2][LENGTH];
    logic [1:0]        r_full;
    logic              r_wp;
    logic              r_rp;
    logic              r_overflow;

    // ------------------------------------------------------------------
    // Read FSM and registered serial outputs
    // ------------------------------------------------------------------
    state_t            r_state;
    state_t            w_state_nxt;
    logic [IBITS-1:0]  r_cnt;
    logic              r_valid;
    logic              r_first;
    logic              r_last;
    logic [IBITS-1:0]  r_index;
    logic [WIDTH-1:0]  r_rdata;
    logic [WIDTH-1:0]  r_idata;

    // ------------------------------------------------------------------
    // Fill side
    // ------------------------------------------------------------------
    logic              w_wfull;
    logic [LENGTH-1:0] w_cap;
    logic [LENGTH-1:0] w_mask_nxt;
    logic              w_drop;
    logic              w_complete;

    assign w_wfull    = r_full[r_wp];
    // A lane is taken only into a free bank and only once per bank.
    assign w_cap      = bus.par_valid_i & ~r_mask[r_wp] & {LENGTH{~w_wfull}};
    assign w_drop     = |(bus.par_valid_i & (r_mask[r_wp] | {LENGTH{w_wfull}}));
    // Completion looks at the mask including this edge's captures, so a
    // bank whose lanes all arrive together closes in a single edge.
    assign w_mask_nxt = r_mask[r_wp] | w_cap;
    assign w_complete = ~w_wfull & (&w_mask_nxt);

    // ------------------------------------------------------------------
    // Read FSM next-state and word-load decisions
    // ------------------------------------------------------------------
    logic              w_ld;
    logic              w_ld_bank;
    logic [IBITS-1:0]  w_ld_cnt;
    logic [IBITS-1:0]  w_ld_idx;
    logic              w_release;

    always_comb begin
        w_state_nxt = r_state;
        w_ld        = 1'b0;
        w_ld_bank   = r_rp;
        w_ld_cnt    = '0;
        w_release   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_full[r_rp]) begin
                    w_ld        = 1'b1;
                    w_state_nxt = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.seq_ready_i) begin
                    if (r_cnt != LAST) begin
                        w_ld     = 1'b1;
                        w_ld_cnt = r_cnt + 1'b1;
                    end else begin
                        // Last word leaves: free this bank and, if the
                        // other one is already waiting, start it with no gap.
                        w_release = 1'b1;
                        if (r_full[~r_rp]) begin
                            w_ld      = 1'b1;
                            w_ld_bank = ~r_rp;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Word count always runs 0..LAST; the lane index is mapped from it.
    assign w_ld_idx = (REVERSE != 0) ? (LAST - w_ld_cnt) : w_ld_cnt;

    // ------------------------------------------------------------------
    // Fill-side state, full flags and pointers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                r_mask[b] <= '0;
                for (int k = 0; k < LENGTH; k++) begin
                    r_re[b][k] <= '0;
                    r_im[b][k] <= '0;
                end
            end
            r_full     <= '0;
            r_wp       <= 1'b0;
            r_rp       <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            for (int k = 0; k < LENGTH; k++) begin
                if (w_cap[k]) begin
                    r_re[r_wp][k] <= bus.par_rdata_i[k*WIDTH +: WIDTH];
                    r_im[r_wp][k] <= bus.par_idata_i[k*WIDTH +: WIDTH];
                end
            end
            if (w_complete) begin
                r_mask[r_wp] <= '0;
                r_wp         <= ~r_wp;
            end else begin
                r_mask[r_wp] <= w_mask_nxt;
            end
            // Completion needs bank[wp] free and release needs bank[rp]
            // full, so the two never target the same flag in one edge.
            if (w_complete) begin
                r_full[r_wp] <= 1'b1;
            end
            if (w_release) begin
                r_full[r_rp] <= 1'b0;
                r_rp         <= ~r_rp;
            end
            // A drop in the same cycle as clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (bus.clear_i) begin
                r_overflow <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM state register and registered serial outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_first <= 1'b0;
            r_last  <= 1'b0;
            r_index <= '0;
            r_rdata <= '0;
            r_idata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_ld) begin
                r_valid <= 1'b1;
                r_cnt   <= w_ld_cnt;
                r_index <= w_ld_idx;
                r_first <= (w_ld_cnt == '0);
                r_last  <= (w_ld_cnt == LAST);
                r_rdata <= r_re[w_ld_bank][w_ld_idx];
                r_idata <= r_im[w_ld_bank][w_ld_idx];
            end else if (w_release) begin
                r_valid <= 1'b0;
                r_first <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.par_ready_o = ~r_full[r_wp];
    assign bus.seq_valid_o = r_valid;
    assign bus.seq_first_o = r_first;
    assign bus.seq_last_o  = r_last;
    assign bus.seq_index_o = r_index;
    assign bus.seq_rdata_o = r_rdata;
    assign bus.seq_idata_o = r_idata;
    assign bus.overflow_o  = r_overflow;
    assign dbg_state_o     = r_state;

endmodule

// File: tb/tb_visdrain.sv
// ---------------------------------------------------------------------------
// tb_visdrain
//   Two drains (REVERSE=0 and REVERSE=1, LENGTH=4, WIDTH=8) receive the same
//   stimulus. Expected words for each are queued when a bank is driven and
//   compared as words are accepted downstream.
// ---------------------------------------------------------------------------
module tb_visdrain;
    localparam int L = 4;
    localparam int W = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    visdrain_if #(.LENGTH(L), .WIDTH(W)) bus0 ();
    visdrain_if #(.LENGTH(L), .WIDTH(W)) bus1 ();
    logic dbg0;
    logic dbg1;

    visdrain #(.LENGTH(L), .WIDTH(W), .REVERSE(0)) dut0 (
        .clock(clk), .reset(rst), .bus(bus0), .dbg_state_o(dbg0)
    );
    visdrain #(.LENGTH(L), .WIDTH(W), .REVERSE(1)) dut1 (
        .clock(clk), .reset(rst), .bus(bus1), .dbg_state_o(dbg1)
    );

    // ---------------- scoreboard ----------------
    // entry = {first, last, index[1:0], rdata[7:0], idata[7:0]}
    logic [19:0] exp_q0[$];
    logic [19:0] exp_q1[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (bus0.seq_valid_o && bus0.seq_ready_i) begin
                if (exp_q0.size() > 0)
                    chk("word_fwd", {12'b0, bus0.seq_first_o, bus0.seq_last_o, bus0.seq_index_o,
                                     bus0.seq_rdata_o, bus0.seq_idata_o}, {12'b0, exp_q0.pop_front()});
                else
                    chk("extra_word_fwd", 32'(exp_q0.size()), 32'd1);
            end
            if (bus1.seq_valid_o && bus1.seq_ready_i) begin
                if (exp_q1.size() > 0)
                    chk("word_rev", {12'b0, bus1.seq_first_o, bus1.seq_last_o, bus1.seq_index_o,
                                     bus1.seq_rdata_o, bus1.seq_idata_o}, {12'b0, exp_q1.pop_front()});
                else
                    chk("extra_word_rev", 32'(exp_q1.size()), 32'd1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lanes(input logic [3:0] v, input logic [31:0] rv, input logic [31:0] iv);
        bus0.par_valid_i = v;  bus1.par_valid_i = v;
        bus0.par_rdata_i = rv; bus1.par_rdata_i = rv;
        bus0.par_idata_i = iv; bus1.par_idata_i = iv;
    endtask

    task automatic set_ready(input logic r);
        bus0.seq_ready_i = r;
        bus1.seq_ready_i = r;
    endtask

    task automatic set_clear(input logic c);
        bus0.clear_i = c;
        bus1.clear_i = c;
    endtask

    task automatic push_bank(input logic [31:0] rv, input logic [31:0] iv);
        for (int n = 0; n < 4; n++) begin
            automatic int k0 = n;
            automatic int k1 = 3 - n;
            exp_q0.push_back({n == 0, n == 3, 2'(k0), rv[k0*8 +: 8], iv[k0*8 +: 8]});
            exp_q1.push_back({n == 0, n == 3, 2'(k1), rv[k1*8 +: 8], iv[k1*8 +: 8]});
        end
    endtask

    task automatic wait_drain(input string tag);
        automatic int n = 0;
        set_ready(1'b1);
        while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 80) begin
            cyc();
            n++;
        end
        chk(tag, 32'(exp_q0.size() + exp_q1.size()), 32'd0);
    endtask

    task automatic chk_valid(input string tag, input logic exp);
        chk({tag, "_fwd"}, {31'b0, bus0.seq_valid_o}, {31'b0, exp});
        chk({tag, "_rev"}, {31'b0, bus1.seq_valid_o}, {31'b0, exp});
    endtask

    task automatic chk_ovf(input string tag, input logic exp);
        chk({tag, "_fwd"}, {31'b0, bus0.overflow_o}, {31'b0, exp});
        chk({tag, "_rev"}, {31'b0, bus1.overflow_o}, {31'b0, exp});
    endtask

    task automatic chk_pready(input string tag, input logic exp);
        chk({tag, "_fwd"}, {31'b0, bus0.par_ready_o}, {31'b0, exp});
        chk({tag, "_rev"}, {31'b0, bus1.par_ready_o}, {31'b0, exp});
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0]  sent;
        logic [3:0]  v;
        logic [31:0] rv;
        logic [31:0] iv;

        set_lanes(4'h0, 32'h0, 32'h0);
        set_ready(1'b1);
        set_clear(1'b0);

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk_valid("rst_valid", 1'b0);
        chk("rst_first", {31'b0, bus0.seq_first_o}, 32'd0);
        chk("rst_last",  {31'b0, bus0.seq_last_o},  32'd0);
        chk("rst_index", {30'b0, bus0.seq_index_o}, 32'd0);
        chk("rst_rdata", {24'b0, bus1.seq_rdata_o}, 32'd0);
        chk("rst_idata", {24'b0, bus1.seq_idata_o}, 32'd0);
        chk("rst_state", {31'b0, dbg0}, 32'd0);
        chk_ovf("rst_ovf", 1'b0);
        chk_pready("rst_pready", 1'b1);
        repeat (3) cyc();
        rst = 1'b0;
        cyc();

        // All lanes in one cycle: words at +1..+4
        push_bank(32'h13121110, 32'h23222120);
        set_lanes(4'hF, 32'h13121110, 32'h23222120);
        cyc();
        set_lanes(4'h0, 32'h0, 32'h0);
        chk_valid("t1_lat0", 1'b0);
        chk_pready("t1_pready", 1'b1);
        for (int k = 1; k <= 4; k++) begin
            cyc();
            chk_valid("t1_burst", 1'b1);
            if (k == 1) chk("t1_state", {31'b0, dbg0}, 32'd1);
        end
        cyc();
        chk_valid("t1_end", 1'b0);
        wait_drain("t1_drain");

        // Staggered lanes 3,1,0,2
        push_bank(32'h43424140, 32'h53525150);
        set_lanes(4'b1000, 32'h43424140, 32'h53525150); cyc();
        set_lanes(4'b0010, 32'h43424140, 32'h53525150); cyc();
        set_lanes(4'b0001, 32'h43424140, 32'h53525150); cyc();
        chk_valid("t2_partial", 1'b0);
        set_lanes(4'b0100, 32'h43424140, 32'h53525150); cyc();
        set_lanes(4'h0, 32'h0, 32'h0);
        chk_valid("t2_lat0", 1'b0);
        cyc();
        chk_valid("t2_lat1", 1'b1);
        chk("t2_first_idx_rev", {30'b0, bus1.seq_index_o}, 32'd3);
        wait_drain("t2_drain");
        chk_ovf("t2_ovf", 1'b0);

        // Backpressure on word 1 for 5 cycles
        push_bank(32'h7B7A7978, 32'h8B8A8988);
        set_lanes(4'hF, 32'h7B7A7978, 32'h8B8A8988);
        cyc();                                   // completing edge
        set_lanes(4'h0, 32'h0, 32'h0);
        cyc();                                   // word 0 shown
        cyc();                                   // word 0 accepted, word 1 shown
        set_ready(1'b0);
        for (int j = 0; j < 5; j++) begin
            chk_valid("t3_hold_valid", 1'b1);
            chk("t3_hold_idx_fwd", {30'b0, bus0.seq_index_o}, 32'd1);
            chk("t3_hold_dat_fwd", {24'b0, bus0.seq_rdata_o}, 32'h79);
            chk("t3_hold_idx_rev", {30'b0, bus1.seq_index_o}, 32'd2);
            chk("t3_hold_dat_rev", {24'b0, bus1.seq_idata_o}, 32'h8A);
            cyc();
        end
        chk("t3_hold_last_idx", {30'b0, bus0.seq_index_o}, 32'd1);
        set_ready(1'b1);
        cyc();                                   // word 1 accepted
        cyc();                                   // word 2 accepted
        chk_valid("t3_w3", 1'b1);
        chk("t3_w3_last", {31'b0, bus0.seq_last_o}, 32'd1);
        cyc();                                   // word 3 accepted
        chk_valid("t3_end", 1'b0);
        wait_drain("t3_drain");

        // Three banks with ready low: third is dropped
        set_ready(1'b0);
        push_bank(32'hA3A2A1A0, 32'hB3B2B1B0);
        push_bank(32'hC3C2C1C0, 32'hD3D2D1D0);
        set_lanes(4'hF, 32'hA3A2A1A0, 32'hB3B2B1B0); cyc();
        chk_pready("t4_pready1", 1'b1);
        set_lanes(4'hF, 32'hC3C2C1C0, 32'hD3D2D1D0); cyc();
        chk_pready("t4_pready2", 1'b0);
        chk_ovf("t4_ovf_pre", 1'b0);
        set_lanes(4'hF, 32'hE3E2E1E0, 32'hF3F2F1F0); cyc();
        set_lanes(4'h0, 32'h0, 32'h0);
        chk_ovf("t4_ovf", 1'b1);
        set_ready(1'b1);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            if (k < 8) chk_valid("t4_stream", 1'b1);
            else       chk_valid("t4_stream_end", 1'b0);
            if (k == 3) chk_pready("t4_pready_busy", 1'b0);
            if (k == 4) begin
                chk_pready("t4_pready_freed", 1'b1);
                chk("t4_second_first", {31'b0, bus0.seq_first_o}, 32'd1);
            end
        end
        wait_drain("t4_drain");
        set_clear(1'b1); cyc(); set_clear(1'b0);
        chk_ovf("t4_clear", 1'b0);

        // Lane 1 strobed twice; clear on the drop cycle loses to the drop
        push_bank(32'h63626160, 32'h73727170);
        set_lanes(4'b0010, 32'h00006100, 32'h00007100); cyc();
        chk_ovf("t5_first_strobe", 1'b0);
        set_clear(1'b1);
        set_lanes(4'b0010, 32'h00009900, 32'h00009900); cyc();
        set_clear(1'b0);
        chk_ovf("t5_dup_drop", 1'b1);
        set_lanes(4'b1101, 32'h6362EE60, 32'h7372EE70); cyc();
        set_lanes(4'h0, 32'h0, 32'h0);
        wait_drain("t5_drain");
        chk_ovf("t5_sticky", 1'b1);
        set_clear(1'b1); cyc(); set_clear(1'b0);
        chk_ovf("t5_clear", 1'b0);

        // Reset during word 2 of an emission
        push_bank(32'h97969594, 32'hA7A6A5A4);
        set_lanes(4'hF, 32'h97969594, 32'hA7A6A5A4); cyc();
        set_lanes(4'h0, 32'h0, 32'h0);
        cyc(); cyc(); cyc();                      // word 2 now showing
        #2 rst = 1'b1;
        #1;
        chk_valid("t6_rst_valid", 1'b0);
        chk("t6_rst_first", {31'b0, bus1.seq_first_o}, 32'd0);
        exp_q0.delete();
        exp_q1.delete();
        cyc(); cyc();
        rst = 1'b0;
        chk_pready("t6_pready", 1'b1);
        for (int k = 0; k < 6; k++) begin
            cyc();
            chk_valid("t6_quiet", 1'b0);
        end
        push_bank(32'h5A5B5C5D, 32'h6A6B6C6D);
        set_lanes(4'hF, 32'h5A5B5C5D, 32'h6A6B6C6D); cyc();
        set_lanes(4'h0, 32'h0, 32'h0);
        wait_drain("t6_drain");

        // Random banks, random lane arrival and random ready
        for (int b = 0; b < 6; b++) begin
            rv = $urandom;
            iv = $urandom;
            push_bank(rv, iv);
            sent = 4'h0;
            for (int n = 0; n < 100 && sent != 4'hF; n++) begin
                set_ready(1'($urandom_range(0, 1)));
                if (bus0.par_ready_o) begin
                    v = 4'($urandom) & ~sent;
                    set_lanes(v, rv, iv);
                    sent = sent | v;
                end else begin
                    set_lanes(4'h0, 32'h0, 32'h0);
                end
                cyc();
            end
            set_lanes(4'h0, 32'h0, 32'h0);
            chk("rand_bank_sent", {28'b0, sent}, 32'hF);
        end
        wait_drain("rand_drain");
        chk_ovf("rand_ovf", 1'b0);
        repeat (3) cyc();
        chk_valid("final_idle", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/visdrain.md
VISDRAIN -- requirements
Module: visdrain

Interface
REQ-001 Parameter LENGTH, default 5: number of parallel correlator lanes; legal range 2..64.
REQ-002 Parameter WIDTH, default 7: bits per real/imag value.
REQ-003 Parameter REVERSE, default 1: 0 = emit lane 0 first; 1 = emit lane LENGTH-1 first.
REQ-004 Local IBITS = $clog2(LENGTH): lane-index width.
REQ-005 clock  in  1  single clock; all state changes on its rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 par_valid_i  in  LENGTH  per-lane strobe; bit k qualifies lane k data.
REQ-008 par_rdata_i  in  LENGTH*WIDTH  lane k real value at bits [k*WIDTH +: WIDTH].
REQ-009 par_idata_i  in  LENGTH*WIDTH  lane k imag value, same packing.
REQ-010 par_ready_o  out  1  high when a fill bank is available.
REQ-011 seq_valid_o  out  1  serial word valid.
REQ-012 seq_ready_i  in  1  downstream accept; a transfer occurs when valid and ready are both high.
REQ-013 seq_first_o / seq_last_o  out  1 each  first/last word of a bank.
REQ-014 seq_index_o  out  IBITS  source lane of the current word.
REQ-015 seq_rdata_o / seq_idata_o  out  WIDTH each  current word data.
REQ-016 clear_i  in  1  synchronous clear of overflow_o.
REQ-017 overflow_o  out  1  sticky; set when lane data is dropped.

Function
REQ-018 Storage: two banks (A/B), each with LENGTH real+imag registers and a LENGTH-bit captured mask; fill pointer wp, read pointer rp, full flag per bank.
REQ-019 Capture: when par_valid_i[k]=1, bank[wp] is not full and mask[k]=0, the edge stores lane k data and sets mask[k].
REQ-020 Drop: when par_valid_i[k]=1 and either bank[wp] is full or mask[k]=1, lane k data is discarded and overflow_o is set at that edge.
REQ-021 Completion: when the mask, including lanes captured this edge, becomes all ones, the same edge sets full[wp], clears the mask and toggles wp; all lanes in one cycle complete the bank in one edge.
REQ-022 par_ready_o = !full[wp], derived from registered state only.
REQ-023 Read FSM states: IDLE (seq_valid_o=0) and EMIT (seq_valid_o=1); outputs are registered.
REQ-024 IDLE->EMIT: at the first edge after full[rp] is observed set, load word 0; latency is 1 cycle from the completing edge.
REQ-025 Word order: index sequence 0..LENGTH-1 if REVERSE=0, else LENGTH-1..0; seq_first_o is high on the first word, seq_last_o on the last word; both are high only if LENGTH=1, which is disallowed.
REQ-026 While seq_valid_o=1 and seq_ready_i=0, all seq_* outputs hold stable.
REQ-027 Transfer of a non-last word: the next word loads at the same edge, with no bubble.
REQ-028 Transfer of the last word: the same edge clears full[rp] and toggles rp; if the other bank is full, its word 0 loads at that edge (zero bubble), else go to IDLE.
REQ-029 Freeing a bank becomes visible on par_ready_o in the following cycle; lane strobes at the freeing edge while bank[wp] is full are dropped per REQ-020.
REQ-030 clear_i=1 clears overflow_o; a simultaneous drop wins and overflow_o stays 1.
REQ-031 No arithmetic is performed; data passes bit-exact.

Reset
REQ-032 Asserting reset asynchronously clears: masks, full flags, wp=rp=0, state=IDLE, seq_valid_o/first/last=0, seq_index_o=0, seq data=0, overflow_o=0; par_ready_o=1 after reset.
REQ-033 Reset mid-bank or mid-emission discards all held data; no partial bank is emitted after release.

Verification (LENGTH=4, WIDTH=8)
REQ-034 All four lanes valid in one cycle (r=0x10..0x13, i=0x20..0x23), REVERSE=0, ready=1 -> words at cycles +1..+4 with index 0,1,2,3, r 0x10..0x13, first on 0x10, last on 0x13.
REQ-035 Lanes arrive staggered (3,1,0,2 on separate cycles), REVERSE=1 -> emission starts 1 cycle after lane 2 arrives, order 3,2,1,0, overflow_o=0.
REQ-036 Backpressure: ready=0 for 5 cycles on word 1 -> word 1 held for 5 cycles unchanged; full sequence completes in 4+5 cycles.
REQ-037 Three complete banks with ready=0 -> banks A/B fill, par_ready_o=0, third bank dropped with overflow_o=1; on ready=1, exactly 8 words emitted back-to-back with no bubble; clear_i -> overflow_o=0.
REQ-038 Lane 1 strobed twice before bank completes -> second value dropped, first value emitted, overflow_o=1.
REQ-039 Reset asserted during word 2 of emission -> seq_valid_o=0 immediately; after release, par_ready_o=1 and no words are emitted until a new full bank arrives.
